// File: rtl/seg_time_display_if.sv
// seg_time_display_if: time inputs and multiplexed seven-segment drive of seg_time_display
interface seg_time_display_if;
  logic [7:0] sec_in;
  logic [7:0] min_in;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;
  modport master (output sec_in, min_in, input seg, dp, an, busy);
  modport slave (input sec_in, min_in, output seg, dp, an, busy);
endinterface

// File: rtl/seg_time_display.sv
// seg_time_display: MM.SS on a 4-digit multiplexed display via iterative binary-to-BCD conversion
module seg_time_display #(
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst,
  seg_time_display_if.slave io_disp
);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {CAPTURE, CONV_MIN, CONV_SEC, UPDATE} state_t;
  state_t          r_state;
  logic            r_busy;
  logic [6:0]      r_min_rem;
  logic [6:0]      r_sec_rem;
  logic [3:0]      r_min_tens;
  logic [3:0]      r_sec_tens;
  logic [3:0][3:0] r_d;
  logic [DW-1:0]   r_div;
  logic [1:0]      r_idx;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;
  logic            r_dp;
  logic            w_wrap;
  logic [1:0]      w_idx_next;
  logic [3:0][3:0] w_d_next;
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0: seg_enc = 7'b1000000;
      4'd1: seg_enc = 7'b1111001;
      4'd2: seg_enc = 7'b0100100;
      4'd3: seg_enc = 7'b0110000;
      4'd4: seg_enc = 7'b0011001;
      4'd5: seg_enc = 7'b0010010;
      4'd6: seg_enc = 7'b0000010;
      4'd7: seg_enc = 7'b1111000;
      4'd8: seg_enc = 7'b0000000;
      4'd9: seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= CAPTURE;
      r_busy     <= 1'b0;
      r_min_rem  <= '0;
      r_sec_rem  <= '0;
      r_min_tens <= '0;
      r_sec_tens <= '0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_min_rem  <= io_disp.min_in > 8'd99 ? 7'd99 : io_disp.min_in[6:0];
          r_sec_rem  <= io_disp.sec_in > 8'd99 ? 7'd99 : io_disp.sec_in[6:0];
          r_min_tens <= '0;
          r_sec_tens <= '0;
          r_state    <= CONV_MIN;
          r_busy     <= 1'b1;
        end
        CONV_MIN:
          if (r_min_rem >= 7'd10) begin
            r_min_rem  <= r_min_rem - 7'd10;
            r_min_tens <= r_min_tens + 4'd1;
          end else r_state <= CONV_SEC;
        CONV_SEC:
          if (r_sec_rem >= 7'd10) begin
            r_sec_rem  <= r_sec_rem - 7'd10;
            r_sec_tens <= r_sec_tens + 4'd1;
          end else r_state <= UPDATE;
        default: begin
          r_state <= CAPTURE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  // seg and an are both derived from next-state values so they always switch together
  assign w_wrap     = r_div == DW'(SCAN_DIV - 1);
  assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_d_next   = r_state == UPDATE ? {r_min_tens, r_min_rem[3:0], r_sec_tens, r_sec_rem[3:0]} : r_d;
  always_ff @(posedge clk)
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_d   <= '0;
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
      r_dp  <= 1'b1;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DW'(1);
      r_idx <= w_idx_next;
      r_d   <= w_d_next;
      r_an  <= ~(4'b0001 << w_idx_next);
      r_seg <= seg_enc(w_d_next[w_idx_next]);
      r_dp  <= w_idx_next != 2'd2;
    end
  assign io_disp.seg  = r_seg;
  assign io_disp.an   = r_an;
  assign io_disp.dp   = r_dp;
  assign io_disp.busy = r_busy;
endmodule

// File: tb/tb_seg_time_display.sv
// tb_seg_time_display: per-cycle check of scan, conversion timing and display against a latency-level model
module tb_seg_time_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_time_display_if bus ();
  seg_time_display #(.SCAN_DIV(4)) dut (.clk(clk), .rst(rst), .io_disp(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int disp[4];
  int pend[4];
  int left = 0;
  int cnt = 0;
  logic [6:0] enc_t[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_t[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seen_seg[4];
  logic       seen_dp2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, expv);
    end
  endtask
  // Model: a capture happens whenever no conversion is pending; results appear tm+ts+4 edges later
  task automatic tick();
    int m, s, idx;
    @(posedge clk);
    if (rst) begin
      disp = '{0, 0, 0, 0};
      left = 0;
      cnt  = 0;
    end else begin
      if (left == 0) begin
        m = bus.min_in > 99 ? 99 : int'(bus.min_in);
        s = bus.sec_in > 99 ? 99 : int'(bus.sec_in);
        pend = '{s % 10, s / 10, m % 10, m / 10};
        left = m / 10 + s / 10 + 3;
      end else begin
        left--;
        if (left == 0) disp = pend;
      end
      cnt++;
    end
    #1;
    idx = (cnt / 4) % 4;
    chk("an", 32'(bus.an), 32'(an_t[idx]));
    chk("seg", 32'(bus.seg), 32'(enc_t[disp[idx]]));
    chk("dp", 32'(bus.dp), 32'(idx != 2));
    chk("busy", 32'(bus.busy), 32'(left != 0));
  endtask
  task automatic wait_cap();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("cap_wait", 32'(bus.busy), 32'd0);
  endtask
  task automatic lat(input string tag, input int expv);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy === 1'b1 && n < 40);
    chk(tag, n, expv);
  endtask
  initial begin
    bus.min_in = 8'd0;
    bus.sec_in = 8'd0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_an", 32'(bus.an), 32'b1110);
    chk("rst_seg", 32'(bus.seg), 32'b1000000);
    rst = 1'b0;
    bus.min_in = 8'd59;
    bus.sec_in = 8'd60;
    repeat (40) tick();
    seen_dp2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int k = 0; k < 4; k++) if (bus.an == an_t[k]) seen_seg[k] = bus.seg;
      if (bus.an == 4'b1011) seen_dp2 = bus.dp;
    end
    chk("show_min_tens", 32'(seen_seg[3]), 32'b0010010);
    chk("show_min_ones", 32'(seen_seg[2]), 32'b0010000);
    chk("show_dp", 32'(seen_dp2), 32'd0);
    chk("show_sec_tens", 32'(seen_seg[1]), 32'b0000010);
    chk("show_sec_ones", 32'(seen_seg[0]), 32'b1000000);
    wait_cap();
    bus.min_in = 8'd200;
    bus.sec_in = 8'd255;
    lat("clamp_latency", 22);
    repeat (20) tick();
    wait_cap();
    bus.min_in = 8'd12;
    bus.sec_in = 8'd59;
    tick();
    tick();
    bus.sec_in = 8'd0;
    repeat (60) tick();
    bus.sec_in = 8'd34;
    wait_cap();
    lat("conv_1234", 8);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_seg", 32'(bus.seg), 32'b1000000);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.min_in = 8'd7;
    bus.sec_in = 8'd45;
    lat("post_rst_latency", 8);
    repeat (20) tick();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus.min_in = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0) bus.sec_in = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 99));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_time_display.md
SEG_TIME_DISPLAY -- requirements
Module: seg_time_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit is held active (legal range >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge system clock, the single clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sec_in  input  8  unsigned binary seconds value from the upstream time counter.
REQ-005 SHALL have port min_in  input  8  unsigned binary minutes value from the upstream time counter.
REQ-006 SHALL have port seg  output  7  active-low segment drive, seg[0]=a through seg[6]=g.
REQ-007 SHALL have port dp  output  1  active-low decimal point.
REQ-008 SHALL have port an  output  4  active-low digit enable, one-hot-low.
REQ-009 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-010 SHALL run continuously with FSM states CAPTURE, CONV_MIN, CONV_SEC, UPDATE; no idle state, no start handshake.
REQ-011 CAPTURE (1 cycle) SHALL register min_in and sec_in, each clamped to 99 if > 99, clear both tens counters, then go to CONV_MIN.
REQ-012 CONV_MIN SHALL, per cycle: if min remainder >= 10, subtract 10 and increment min tens; otherwise go to CONV_SEC. It therefore lasts (min tens + 1) cycles.
REQ-013 CONV_SEC SHALL behave identically for seconds, then go to UPDATE.
REQ-014 UPDATE (1 cycle) SHALL load all four display digit registers together, then go to CAPTURE.
REQ-015 Conversion latency from CAPTURE to new digits visible SHALL be tm+ts+4 cycles, max 22 cycles.
REQ-016 Display digits SHALL change only in UPDATE; partial results SHALL never reach seg.
REQ-017 Input changes outside the CAPTURE cycle SHALL be ignored until the next CAPTURE.
REQ-018 busy SHALL be 0 in CAPTURE and 1 in CONV_MIN, CONV_SEC and UPDATE.
REQ-019 A scan divider SHALL count 0..SCAN_DIV-1 and wrap to 0. On reaching SCAN_DIV-1, a 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-020 The digit index SHALL select the displayed digit and its an pattern:
- 0: seconds ones, an=1110
- 1: seconds tens, an=1101
- 2: minutes ones, an=1011
- 3: minutes tens, an=0111
REQ-021 dp SHALL be 0 (lit) only when digit index is 2; otherwise 1.
REQ-022 seg SHALL be registered, changing in the same cycle as an.
REQ-023 seg SHALL use these active-low encodings:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-024 Any digit value above 9 SHALL drive seg=1111111 (blank); this is not reachable with the clamp and serves as a defensive default.
REQ-025 Scan and conversion SHALL run independently; an UPDATE mid-scan-period SHALL take effect on seg in the next cycle without disturbing the scan divider or digit index.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL set:
- FSM=CAPTURE, busy=0
- scan divider=0, digit index=0
- all digit registers=0
- an=1110, seg=1000000, dp=1
REQ-027 rst asserted mid-conversion SHALL abandon the conversion without updating the display. The first CAPTURE SHALL occur on the first clk edge after rst deasserts.

Verification
REQ-028 Reset: assert rst 2 cycles with SCAN_DIV=4 -> an=1110, seg=1000000, dp=1, busy=0; after release, an steps 1110->1101->1011->0111->1110 every 4 cycles.
REQ-029 Conversion: min_in=59, sec_in=60 held -> within 19 cycles of CAPTURE the digits read 5,9,6,0. The bench SHALL observe seg=0010010 with an=0111, seg=0010000 with an=1011 and dp=0, seg=0000010 with an=1101, and seg=1000000 with an=1110.
REQ-030 Clamp: min_in=200, sec_in=255 -> display reads 99.99 and the conversion spans exactly 22 cycles from CAPTURE to UPDATE inclusive of visibility.
REQ-031 Atomicity: change sec_in 59->0 during CONV_MIN -> the display holds the old value until the next full cycle, then shows 00 seconds; seg never shows a mixed or partial digit.
REQ-032 Reset mid-operation: assert rst during CONV_SEC with display 12.34 -> display becomes 00.00 and busy=0 next cycle; after release, the new values appear within tm+ts+4 cycles.
